// File: rtl/rf_write_arbiter.sv
// Write-port sequencer for the 8x8 register file: clears every register after
// reset, then shares the single write port among ALU, load and debug requesters.
module rf_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [2:0]        REQ_VALID,
  output logic [2:0]        REQ_READY,
  input  logic [ADDR_W-1:0] REQ_ADDR0,
  input  logic [ADDR_W-1:0] REQ_ADDR1,
  input  logic [ADDR_W-1:0] REQ_ADDR2,
  input  logic [DATA_W-1:0] REQ_DATA0,
  input  logic [DATA_W-1:0] REQ_DATA1,
  input  logic [DATA_W-1:0] REQ_DATA2,
  output logic              WRITE,
  output logic [ADDR_W-1:0] INADDRESS,
  output logic [DATA_W-1:0] IN,
  output logic [1:0]        GRANT_ID,
  output logic              INIT_DONE
);

  // state | meaning
  // INIT  | clear sweep, write port walks addresses 0..NREGS-1 with zero data
  // ARB   | round-robin arbitration among the three requesters
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_ARB  = 1'b1;

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);
  localparam logic [1:0] NO_GRANT = 2'd3;

  logic [0:0]        state;
  logic [ADDR_W-1:0] sweep_cnt;
  logic [1:0]        rr_ptr;

  logic [3:0]        valid_ext;
  logic [1:0]        cand_a, cand_b, cand_c;
  logic [1:0]        sel;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  // Search order starts one past the last granted requester and wraps mod 3.
  always_comb begin
    valid_ext = {1'b0, REQ_VALID};
    cand_a    = 2'd0;
    cand_b    = 2'd1;
    cand_c    = 2'd2;
    case (rr_ptr)
      2'd0: begin cand_a = 2'd1; cand_b = 2'd2; cand_c = 2'd0; end
      2'd1: begin cand_a = 2'd2; cand_b = 2'd0; cand_c = 2'd1; end
      default: begin cand_a = 2'd0; cand_b = 2'd1; cand_c = 2'd2; end
    endcase

    sel       = 2'd0;
    sel_valid = 1'b0;
    if (state == ST_ARB) begin
      if (valid_ext[cand_a]) begin
        sel       = cand_a;
        sel_valid = 1'b1;
      end else if (valid_ext[cand_b]) begin
        sel       = cand_b;
        sel_valid = 1'b1;
      end else if (valid_ext[cand_c]) begin
        sel       = cand_c;
        sel_valid = 1'b1;
      end
    end

    REQ_READY = sel_valid ? (3'b001 << sel) : 3'b000;

    sel_addr = REQ_ADDR0;
    sel_data = REQ_DATA0;
    case (sel)
      2'd1: begin sel_addr = REQ_ADDR1; sel_data = REQ_DATA1; end
      2'd2: begin sel_addr = REQ_ADDR2; sel_data = REQ_DATA2; end
      default: begin sel_addr = REQ_ADDR0; sel_data = REQ_DATA0; end
    endcase
  end

  // RESET has priority, so a handshake coinciding with it never issues a write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
      rr_ptr    <= 2'd2;
      WRITE     <= 1'b0;
      INADDRESS <= '0;
      IN        <= '0;
      GRANT_ID  <= NO_GRANT;
      INIT_DONE <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          WRITE     <= 1'b1;
          INADDRESS <= sweep_cnt;
          IN        <= '0;
          GRANT_ID  <= NO_GRANT;
          sweep_cnt <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_ADDR) begin
            state     <= ST_ARB;
            INIT_DONE <= 1'b1;
          end
        end
        default: begin
          if (sel_valid) begin
            WRITE     <= 1'b1;
            INADDRESS <= sel_addr;
            IN        <= sel_data;
            GRANT_ID  <= sel;
            rr_ptr    <= sel;
          end else begin
            WRITE    <= 1'b0;
            GRANT_ID <= NO_GRANT;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: stimulus queues the expected writes,
// a negedge monitor pops and compares every cycle the write port is active.
module tb_rf_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] valid = 3'b000;
  logic [2:0] ready;
  logic [2:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [7:0] data0 = '0, data1 = '0, data2 = '0;
  logic       wr;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [1:0] gid;
  logic       done;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
    logic [1:0] gid;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  rf_write_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
    .CLK(clk), .RESET(rst),
    .REQ_VALID(valid), .REQ_READY(ready),
    .REQ_ADDR0(addr0), .REQ_ADDR1(addr1), .REQ_ADDR2(addr2),
    .REQ_DATA0(data0), .REQ_DATA1(data1), .REQ_DATA2(data2),
    .WRITE(wr), .INADDRESS(waddr), .IN(wdata),
    .GRANT_ID(gid), .INIT_DONE(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a, input logic [7:0] d, input logic [1:0] g);
    wr_t e;
    e.addr = a; e.data = d; e.gid = g;
    exp_q.push_back(e);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < 8; i++) push(3'(i), 8'h00, 2'd3);
  endtask

  // Monitor: every active write must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && wr === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0h data %0h gid %0d, queue empty", waddr, wdata, gid);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", 32'(waddr), 32'(e.addr));
        chk("write_data", 32'(wdata), 32'(e.data));
        chk("write_gid",  32'(gid),   32'(e.gid));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_write", 32'(wr), 0);
    chk("rst_addr", 32'(waddr), 0);
    chk("rst_data", 32'(wdata), 0);
    chk("rst_gid", 32'(gid), 3);
    chk("rst_done", 32'(done), 0);
    chk("rst_ready", 32'(ready), 0);

    // Clear sweep, no requests
    push_sweep();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("sweep_done", 32'(done), (i == 8) ? 1 : 0);
    end
    tick();
    chk("idle_write", 32'(wr), 0);
    chk("idle_gid", 32'(gid), 3);

    // All three valid, pointer=2 -> grants rotate 0,1,2,0,1,2
    addr0 = 3'd1; addr1 = 3'd2; addr2 = 3'd4;
    data0 = 8'h40; data1 = 8'h41; data2 = 8'h42;
    valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_ready", 32'(ready), 32'(3'b001 << (k % 3)));
      case (k % 3)
        0: push(3'd1, 8'(8'h40 + k), 2'd0);
        1: push(3'd2, 8'(8'h40 + k), 2'd1);
        default: push(3'd4, 8'(8'h40 + k), 2'd2);
      endcase
      tick();
      chk("rr_write_high", 32'(wr), 1);
      case (k % 3)
        0: data0 = 8'(8'h40 + k + 3);
        1: data1 = 8'(8'h40 + k + 3);
        default: data2 = 8'(8'h40 + k + 3);
      endcase
    end
    valid = 3'b000;
    tick();

    // Same address from 0 and 2 with pointer=2: 0 first, then 2 (0x22 final)
    addr0 = 3'd3; data0 = 8'h11;
    addr2 = 3'd3; data2 = 8'h22;
    valid = 3'b101;
    #1;
    chk("same_ready0", 32'(ready), 32'(3'b001));
    push(3'd3, 8'h11, 2'd0);
    tick();
    valid = 3'b100;
    #1;
    chk("same_ready2", 32'(ready), 32'(3'b100));
    push(3'd3, 8'h22, 2'd2);
    tick();
    valid = 3'b000;
    tick();
    chk("same_final_addr", 32'(waddr), 3);
    chk("same_final_data", 32'(wdata), 32'h22);

    // Single requester 1
    addr1 = 3'd5; data1 = 8'hA3;
    valid = 3'b010;
    #1;
    chk("single_ready", 32'(ready), 32'(3'b010));
    push(3'd5, 8'hA3, 2'd1);
    tick();
    valid = 3'b000;
    tick();

    // Handshake coinciding with RESET is discarded (pointer=1 -> requester 0 wins)
    addr0 = 3'd6; data0 = 8'h55;
    valid = 3'b001;
    #1;
    chk("rst_hs_ready", 32'(ready), 32'(3'b001));
    rst = 1'b1;
    tick();
    chk("rst_hs_write", 32'(wr), 0);
    chk("rst_hs_gid", 32'(gid), 3);
    chk("rst_hs_done", 32'(done), 0);

    // Requester 2 valid throughout the restarted sweep
    valid = 3'b100;
    addr2 = 3'd7; data2 = 8'h5A;
    push_sweep();
    rst = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("init_ready_low", 32'(ready), 0);
      tick();
    end
    chk("init2_done", 32'(done), 1);
    chk("post_init_ready", 32'(ready), 32'(3'b100));
    push(3'd7, 8'h5A, 2'd2);
    tick();
    valid = 3'b000;
    tick(); tick();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
